// File: rtl/stuff_nrzi_tx.sv
// Serial transmitter: bit stuffing, NRZI line coding and an SE0/J end-of-packet.
// Define SYNC_GEN_EN to have the block emit the 8-bit SYNC (KJKJKJKK) itself after start.
module stuff_nrzi_tx #(
    parameter int STUFF_LEN   = 6,
    parameter int EOP_SE0_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic s_in,
    input  logic last,
    output logic pause,
    output logic busy,
    output logic done,
    output logic dp,
    output logic dm,
    output logic oe
);

    localparam logic [3:0] STUFF_LIM = 4'(STUFF_LEN);
    localparam logic [2:0] SE0_LAST  = 3'(EOP_SE0_CYC - 1);

    // Each state names the action taken at the next clock edge.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
`ifdef SYNC_GEN_EN
        SYNC    = 3'd1,
`endif
        DATA    = 3'd2,
        STUFF   = 3'd3,
        EOP_SE0 = 3'd4,
        EOP_J   = 3'd5
    } state_t;

    state_t     state_r;
    logic [3:0] ones_cnt_r;
    logic [2:0] se0_cnt_r;
    logic       lvl_r;
    logic       eop_pend_r;
`ifdef SYNC_GEN_EN
    logic [2:0] sync_cnt_r;
`endif

    logic       bit_s;
    logic [3:0] bit_ones_s;
    logic       bit_lvl_s;
    logic       bit_stuff_s;
    state_t     data_next_s;

    // Effect of the bit about to go out: NRZI level (1 = J), ones count, stuff request
    always_comb begin
        bit_s = s_in;
`ifdef SYNC_GEN_EN
        if (state_r == SYNC) begin
            bit_s = (sync_cnt_r == 3'd7);
        end else begin
            bit_s = s_in;
        end
`endif
        if (bit_s) begin
            bit_ones_s = ones_cnt_r + 4'd1;
            bit_lvl_s  = lvl_r;
        end else begin
            bit_ones_s = 4'd0;
            bit_lvl_s  = ~lvl_r;
        end
        bit_stuff_s = bit_s && (bit_ones_s == STUFF_LIM);
        if (bit_stuff_s) begin
            data_next_s = STUFF;
        end else if (last) begin
            data_next_s = EOP_SE0;
        end else begin
            data_next_s = DATA;
        end
    end

    // Transmit FSM; every output is registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            ones_cnt_r <= 4'd0;
            se0_cnt_r  <= 3'd0;
            lvl_r      <= 1'b1;
            eop_pend_r <= 1'b0;
`ifdef SYNC_GEN_EN
            sync_cnt_r <= 3'd0;
`endif
            dp    <= 1'b1;
            dm    <= 1'b0;
            oe    <= 1'b0;
            pause <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    // busy is still high during the done cycle, so a start there is dropped
                    oe         <= 1'b0;
                    busy       <= 1'b0;
                    pause      <= 1'b0;
                    dp         <= 1'b1;
                    dm         <= 1'b0;
                    lvl_r      <= 1'b1;
                    ones_cnt_r <= 4'd0;
                    se0_cnt_r  <= 3'd0;
                    eop_pend_r <= 1'b0;
                    if (start && !busy) begin
                        busy <= 1'b1;
`ifdef SYNC_GEN_EN
                        state_r    <= SYNC;
                        pause      <= 1'b1;
                        sync_cnt_r <= 3'd0;
`else
                        state_r    <= data_next_s;
                        pause      <= bit_stuff_s;
                        oe         <= 1'b1;
                        dp         <= bit_lvl_s;
                        dm         <= ~bit_lvl_s;
                        lvl_r      <= bit_lvl_s;
                        ones_cnt_r <= bit_ones_s;
                        eop_pend_r <= last;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
`ifdef SYNC_GEN_EN
                SYNC: begin
                    oe         <= 1'b1;
                    dp         <= bit_lvl_s;
                    dm         <= ~bit_lvl_s;
                    lvl_r      <= bit_lvl_s;
                    ones_cnt_r <= bit_ones_s;
                    eop_pend_r <= 1'b0;
                    sync_cnt_r <= sync_cnt_r + 3'd1;
                    if (sync_cnt_r == 3'd7) begin
                        state_r <= bit_stuff_s ? STUFF : DATA;
                        pause   <= bit_stuff_s;
                    end else begin
                        state_r <= SYNC;
                        pause   <= 1'b1;
                    end
                end
`endif
                DATA: begin
                    state_r    <= data_next_s;
                    pause      <= bit_stuff_s;
                    oe         <= 1'b1;
                    dp         <= bit_lvl_s;
                    dm         <= ~bit_lvl_s;
                    lvl_r      <= bit_lvl_s;
                    ones_cnt_r <= bit_ones_s;
                    eop_pend_r <= last;
                end
                STUFF: begin
                    // the stuffed 0 toggles the line and restarts the run of ones
                    oe         <= 1'b1;
                    pause      <= 1'b0;
                    dp         <= ~lvl_r;
                    dm         <= lvl_r;
                    lvl_r      <= ~lvl_r;
                    ones_cnt_r <= 4'd0;
                    state_r    <= eop_pend_r ? EOP_SE0 : DATA;
                end
                EOP_SE0: begin
                    oe    <= 1'b1;
                    pause <= 1'b0;
                    dp    <= 1'b0;
                    dm    <= 1'b0;
                    if (se0_cnt_r == SE0_LAST) begin
                        se0_cnt_r <= 3'd0;
                        state_r   <= EOP_J;
                    end else begin
                        se0_cnt_r <= se0_cnt_r + 3'd1;
                        state_r   <= EOP_SE0;
                    end
                end
                EOP_J: begin
                    oe         <= 1'b1;
                    pause      <= 1'b0;
                    dp         <= 1'b1;
                    dm         <= 1'b0;
                    lvl_r      <= 1'b1;
                    ones_cnt_r <= 4'd0;
                    eop_pend_r <= 1'b0;
                    done       <= 1'b1;
                    state_r    <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    pause   <= 1'b0;
                    oe      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stuff_nrzi_tx.sv
// Self-checking bench for stuff_nrzi_tx: directed packets, reset mid-packet, random packets
// against a symbol-level model of stuffing, NRZI and EOP.
module tb_stuff_nrzi_tx;

    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;
`ifdef SYNC_GEN_EN
    localparam bit SYNC_ON = 1'b1;
`else
    localparam bit SYNC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic a_start, a_s_in, a_last, a_pause, a_busy, a_done, a_dp, a_dm, a_oe;
    logic b_start, b_s_in, b_last, b_pause, b_busy, b_done, b_dp, b_dm, b_oe;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];
    int exp_pause;
    int first_oe;
    int pcnt;

    stuff_nrzi_tx #(.STUFF_LEN(6), .EOP_SE0_CYC(2)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .s_in(a_s_in), .last(a_last),
        .pause(a_pause), .busy(a_busy), .done(a_done), .dp(a_dp), .dm(a_dm), .oe(a_oe)
    );

    stuff_nrzi_tx #(.STUFF_LEN(3), .EOP_SE0_CYC(3)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .s_in(b_s_in), .last(b_last),
        .pause(b_pause), .busy(b_busy), .done(b_done), .dp(b_dp), .dm(b_dm), .oe(b_oe)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic si, input logic la);
        if (sel == 0) begin
            a_start = st; a_s_in = si; a_last = la;
        end else begin
            b_start = st; b_s_in = si; b_last = la;
        end
    endtask

    task automatic sample(input int sel, output logic p, output logic bz, output logic dn,
                          output logic o, output logic [1:0] ln);
        if (sel == 0) begin
            p = a_pause; bz = a_busy; dn = a_done; o = a_oe; ln = {a_dp, a_dm};
        end else begin
            p = b_pause; bz = b_busy; dn = b_done; o = b_oe; ln = {b_dp, b_dm};
        end
    endtask

    // Model: expected line symbols of one packet, from the stuffing/NRZI/EOP rules
    task automatic build_exp(input int sel, input int n, input logic [63:0] bits);
        int lim, nse0, ones, m;
        logic lvl, b;
        logic [71:0] seq;
        lim  = (sel == 0) ? 6 : 3;
        nse0 = (sel == 0) ? 2 : 3;
        exp_q.delete();
        exp_pause = 0;
        ones = 0;
        lvl  = 1'b1;
        seq  = {8'h00, bits};
        m    = n;
        if (SYNC_ON) begin
            seq = {bits, 8'h80};
            m = n + 8;
            exp_pause = 8;
        end
        for (int i = 0; i < m; i++) begin
            b = seq[i];
            if (b) begin
                ones++;
            end else begin
                ones = 0;
                lvl = ~lvl;
            end
            exp_q.push_back(lvl ? SYM_J : SYM_K);
            if (b && ones == lim) begin
                lvl = ~lvl;
                ones = 0;
                exp_pause++;
                exp_q.push_back(lvl ? SYM_J : SYM_K);
            end
        end
        repeat (nse0) exp_q.push_back(SYM_SE0);
        exp_q.push_back(SYM_J);
    endtask

    // Play one packet as upstream (hold s_in while pause=1) and compare the line against the model
    task automatic send(input int sel, input int n, input logic [63:0] bits,
                        input bit now, input bit spur, input string tag);
        int idx, dcnt, busy_low, nsym;
        bit adv, first, fin;
        logic pause_pre, p, bz, dn, o;
        logic [1:0] ln;
        build_exp(sel, n, bits);
        got_q.delete();
        pcnt = 0; first_oe = -1; idx = 0; dcnt = 0; busy_low = 0;
        fin = 1'b0; first = 1'b1; pause_pre = 1'b0;
        if (!now) @(negedge clk);
        drive(sel, 1'b1, bits[0], n == 1);
        for (int cyc = 1; cyc < 600 && !fin; cyc++) begin
            @(posedge clk);
            adv = first ? !SYNC_ON : !pause_pre;
            first = 1'b0;
            @(negedge clk);
            if (adv && idx < n) idx++;
            drive(sel, spur, (idx < n) ? bits[idx] : 1'b0, idx == n - 1);
            sample(sel, p, bz, dn, o, ln);
            if (o) begin
                if (first_oe < 0) first_oe = cyc;
                got_q.push_back(ln);
            end
            if (p) pcnt++;
            if (!bz) busy_low++;
            if (dn) begin
                dcnt++;
                fin = 1'b1;
            end
            pause_pre = p;
        end
        check($sformatf("%s done", tag), dcnt, 1);
        check($sformatf("%s busy", tag), busy_low, 0);
        check($sformatf("%s pause_cycles", tag), pcnt, exp_pause);
        check($sformatf("%s line_len", tag), got_q.size(), exp_q.size());
        nsym = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nsym; i++)
            check($sformatf("%s sym%0d", tag, i), got_q[i], exp_q[i]);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 1'b0);
        sample(sel, p, bz, dn, o, ln);
        check($sformatf("%s after_oe", tag), o, 1'b0);
        check($sformatf("%s after_busy", tag), bz, 1'b0);
        check($sformatf("%s after_done", tag), dn, 1'b0);
    endtask

    initial begin
        logic p, bz, dn, o;
        logic [1:0] ln;
        logic [63:0] bits;
        int idx, n, sel;
        bit adv, first;
        logic pause_pre;

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sample(s, p, bz, dn, o, ln);
            check($sformatf("reset%0d line", s), ln, SYM_J);
            check($sformatf("reset%0d oe", s), o, 1'b0);
            check($sformatf("reset%0d pause", s), p, 1'b0);
            check($sformatf("reset%0d busy", s), bz, 1'b0);
            check($sformatf("reset%0d done", s), dn, 1'b0);
        end
        rst = 1'b0;

        send(0, 8, 64'h80, 1'b0, 1'b0, "sync_bits");
`ifndef SYNC_GEN_EN
        check("sync_bits oe_cycles", got_q.size(), 11);
        check("sync_bits first_oe", first_oe, 1);
`endif
        send(0, 8, 64'hFF, 1'b0, 1'b0, "eight_ones");
`ifndef SYNC_GEN_EN
        check("eight_ones one_pause", pcnt, 1);
        check("eight_ones line_len", got_q.size(), 12);
`endif
        send(0, 6, 64'h3F, 1'b0, 1'b0, "six_ones_last");
`ifndef SYNC_GEN_EN
        check("six_ones_last stuff_sym", got_q[6], SYM_K);
        check("six_ones_last first_se0", got_q[7], SYM_SE0);
`endif
        send(1, 4, 64'hF, 1'b0, 1'b1, "len3_eop3");
`ifndef SYNC_GEN_EN
        check("len3_eop3 one_pause", pcnt, 1);
        check("len3_eop3 line_len", got_q.size(), 9);
`endif
`ifdef SYNC_GEN_EN
        send(0, 8, 64'h87, 1'b0, 1'b0, "token");
        check("token first_oe", first_oe, 2);
        check("token pause8", pcnt, 8);
        check("token pid_cycle10", got_q[8], SYM_K);
`endif

        // Reset while the 4th data bit is presented, then restart on the first free cycle
        bits = 64'h5;
        idx = 0; first = 1'b1; pause_pre = 1'b0;
        @(negedge clk);
        drive(0, 1'b1, bits[0], 1'b0);
        for (int c = 0; c < 40 && idx < 3; c++) begin
            @(posedge clk);
            adv = first ? !SYNC_ON : !pause_pre;
            first = 1'b0;
            @(negedge clk);
            if (adv) idx++;
            drive(0, 1'b0, bits[idx], 1'b0);
            sample(0, p, bz, dn, o, ln);
            pause_pre = p;
        end
        check("rst reach_bit4", idx, 3);
        rst = 1'b1;
        @(negedge clk);
        sample(0, p, bz, dn, o, ln);
        check("rst line", ln, SYM_J);
        check("rst oe", o, 1'b0);
        check("rst busy", bz, 1'b0);
        check("rst pause", p, 1'b0);
        check("rst done", dn, 1'b0);
        rst = 1'b0;
        send(0, 10, 64'h2D5, 1'b1, 1'b0, "after_rst");

        for (int r = 0; r < 24; r++) begin
            sel  = r % 2;
            n    = $urandom_range(1, 24);
            bits = {$urandom, $urandom} | {$urandom, $urandom};
            send(sel, n, bits, 1'b0, 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
